// File: rtl/cdec_ram_loader.sv
// Boot loader for the CDEC core: parses ADR/CNT/data/SUM records from a byte stream,
// writes the data into program RAM and holds the CPU in reset until a valid end record.
module cdec_ram_loader #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic              ClkMst,
  input  logic              Reset,
  input  logic [DATA_W-1:0] iRxData,
  input  logic              iRxValid,
  output logic              oRxReady,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic [DATA_W-1:0] oRamData,
  output logic              oRamWe,
  output logic              oCpuReset,
  output logic              oBusy,
  output logic              oDone,
  output logic              oSumErr
);

  typedef enum logic [2:0] {
    StAddr,
    StCnt,
    StData,
    StSum,
    StHold,
    StRun,
    StErr
  } state_e;

  localparam logic [7:0] HoldLast = 8'(RST_HOLD - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] cnt_q;
  logic [DATA_W-1:0] acc_q;
  logic              end_q;
  logic [7:0]        hold_q;

  logic              accept;
  logic [DATA_W-1:0] acc_sum;

  // oRxReady is registered from the next state, so it always matches state_q.
  assign accept  = iRxValid & oRxReady;
  assign acc_sum = acc_q + iRxData;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StAddr: if (accept) state_d = StCnt;
      StCnt:  if (accept) state_d = (iRxData == '0) ? StSum : StData;
      StData: if (accept && cnt_q == DATA_W'(1)) state_d = StSum;
      StSum: begin
        if (accept) begin
          if (acc_sum != '0)  state_d = StErr;
          else if (end_q)     state_d = StHold;
          else                state_d = StAddr;
        end
      end
      StHold: if (hold_q == HoldLast) state_d = StRun;
      StRun:  state_d = StRun;
      StErr:  state_d = StErr;
      default: state_d = StAddr;
    endcase
  end

  always_ff @(posedge ClkMst or posedge Reset) begin
    if (Reset) begin
      state_q   <= StAddr;
      ptr_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      end_q     <= 1'b0;
      hold_q    <= '0;
      oRamWe    <= 1'b0;
      oRamAddr  <= '0;
      oRamData  <= '0;
      oRxReady  <= 1'b1;
      oBusy     <= 1'b1;
      oCpuReset <= 1'b1;
      oDone     <= 1'b0;
      oSumErr   <= 1'b0;
    end else begin
      state_q <= state_d;
      oRamWe  <= 1'b0;
      case (state_q)
        StAddr: begin
          if (accept) begin
            ptr_q <= ADDR_W'(iRxData);
            acc_q <= iRxData;
          end
        end
        StCnt: begin
          if (accept) begin
            cnt_q <= iRxData;
            acc_q <= acc_sum;
            end_q <= (iRxData == '0);
          end
        end
        StData: begin
          if (accept) begin
            oRamWe   <= 1'b1;
            oRamAddr <= ptr_q;
            oRamData <= iRxData;
            ptr_q    <= ptr_q + ADDR_W'(1);
            cnt_q    <= cnt_q - DATA_W'(1);
            acc_q    <= acc_sum;
          end
        end
        StSum: begin
          if (accept) end_q <= 1'b0;
        end
        StHold: hold_q <= hold_q + 8'd1;
        default: ;
      endcase
      oRxReady  <= state_d inside {StAddr, StCnt, StData, StSum};
      oBusy     <= state_d inside {StAddr, StCnt, StData, StSum, StHold};
      oCpuReset <= (state_d != StRun);
      oDone     <= (state_d == StRun);
      oSumErr   <= (state_d == StErr);
    end
  end

endmodule

// File: tb/tb_cdec_ram_loader.sv
// Randomized bench for cdec_ram_loader: a record-level parser predicts every RAM write,
// the acceptance count and the final outcome; the DUT is checked cycle by cycle.
module tb_cdec_ram_loader;

  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 8;
  localparam int unsigned HOLD = 4;

  logic          ClkMst = 1'b0;
  logic          Reset;
  logic [DW-1:0] iRxData;
  logic          iRxValid;
  logic          oRxReady;
  logic [AW-1:0] oRamAddr;
  logic [DW-1:0] oRamData;
  logic          oRamWe;
  logic          oCpuReset;
  logic          oBusy;
  logic          oDone;
  logic          oSumErr;

  cdec_ram_loader #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RST_HOLD (HOLD)
  ) dut (
    .ClkMst    (ClkMst),
    .Reset     (Reset),
    .iRxData   (iRxData),
    .iRxValid  (iRxValid),
    .oRxReady  (oRxReady),
    .oRamAddr  (oRamAddr),
    .oRamData  (oRamData),
    .oRamWe    (oRamWe),
    .oCpuReset (oCpuReset),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oSumErr   (oSumErr)
  );

  always #5 ClkMst = ~ClkMst;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the byte stream and what each byte means once parsed.
  logic [7:0] stream[$];
  bit         m_data[$];
  logic [7:0] m_addr[$];
  int         m_nacc;
  bit         m_ok;

  function automatic void add_record(input logic [7:0] a, input int n, input bit bad);
    int         s;
    logic [7:0] d;
    logic [7:0] sum;
    s = a + n;
    stream.push_back(a);
    stream.push_back(8'(n));
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom);
      stream.push_back(d);
      s += d;
    end
    sum = 8'((256 - (s % 256)) % 256);
    if (bad) sum = sum ^ 8'($urandom_range(1, 255));
    stream.push_back(sum);
  endfunction

  function automatic void run_model();
    int p;
    int s;
    int n;
    p = 0;
    m_data.delete();
    m_addr.delete();
    m_ok = 1'b0;
    while (p + 2 < stream.size()) begin
      n = stream[p+1];
      s = stream[p] + n;
      repeat (2) begin
        m_data.push_back(1'b0);
        m_addr.push_back(8'h00);
      end
      for (int k = 0; k < n; k++) begin
        m_data.push_back(1'b1);
        m_addr.push_back(8'(stream[p] + k));
        s += stream[p+2+k];
      end
      s += stream[p+2+n];
      m_data.push_back(1'b0);
      m_addr.push_back(8'h00);
      p += n + 3;
      if (s % 256 != 0) break;
      if (n == 0) begin
        m_ok = 1'b1;
        break;
      end
    end
    m_nacc = p;
  endfunction

  // One clock: acceptance is decided by the inputs held across the rising edge.
  task automatic step(input bit is_data, input logic [7:0] a, output bit acc);
    acc = iRxValid && oRxReady;
    @(posedge ClkMst);
    @(negedge ClkMst);
    check("ram_we", oRamWe, 32'(acc && is_data));
    if (acc && is_data) begin
      check("ram_addr", oRamAddr, a);
      check("ram_data", oRamData, iRxData);
    end
  endtask

  task automatic do_reset();
    iRxValid = 1'b0;
    #2 Reset = 1'b1;
    #1;
    check("rst_ready", oRxReady, 1);
    check("rst_busy", oBusy, 1);
    check("rst_cpurst", oCpuReset, 1);
    check("rst_done", oDone, 0);
    check("rst_err", oSumErr, 0);
    check("rst_we", oRamWe, 0);
    check("rst_addr", oRamAddr, 0);
    check("rst_data", oRamData, 0);
    @(posedge ClkMst);
    @(negedge ClkMst);
    Reset = 1'b0;
  endtask

  // mode 0: valid always high, 1: toggling, 2: random
  task automatic run_stream(input int mode, input int lim);
    int i;
    int stall;
    bit tog;
    bit acc;
    i     = 0;
    stall = 0;
    tog   = 1'b1;
    while (i < lim && stall < 64) begin
      iRxValid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog      = !tog;
      iRxData  = iRxValid ? stream[i] : 8'($urandom);
      if (iRxValid) check("ready", oRxReady, 1);
      check("cpurst_load", oCpuReset, 1);
      step(m_data[i], m_addr[i], acc);
      if (acc) begin
        i++;
        stall = 0;
      end else begin
        stall++;
      end
    end
    iRxValid = 1'b0;
    check("accepted", i, lim);
    if (lim < m_nacc) return;
    if (m_ok) begin
      check("busy_hold", oBusy, 1);
      check("cpurst_hold0", oCpuReset, 1);
      for (int j = 1; j <= int'(HOLD); j++) begin
        step(1'b0, 8'h00, acc);
        check("cpurst_hold", oCpuReset, 32'(j < int'(HOLD)));
        check("done_hold", oDone, 32'(j == int'(HOLD)));
        check("ready_hold", oRxReady, 0);
      end
      check("busy_run", oBusy, 0);
      check("err_run", oSumErr, 0);
    end else begin
      check("err_set", oSumErr, 1);
      check("cpurst_err", oCpuReset, 1);
      check("busy_err", oBusy, 0);
      check("done_err", oDone, 0);
      repeat (4) begin
        iRxValid = 1'b1;
        iRxData  = 8'($urandom);
        check("ready_err", oRxReady, 0);
        step(1'b0, 8'h00, acc);
      end
      iRxValid = 1'b0;
      check("err_stays", oSumErr, 1);
      check("cpurst_stays", oCpuReset, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    Reset    = 1'b0;
    iRxValid = 1'b0;
    iRxData  = '0;
    @(negedge ClkMst);
    do_reset();

    stream = '{8'h10, 8'h02, 8'hAA, 8'h55, 8'hEF, 8'h00, 8'h00, 8'h00};
    run_model();
    run_stream(0, m_nacc);

    do_reset();
    run_stream(1, m_nacc);

    do_reset();
    stream = '{8'hFF, 8'h02, 8'h01, 8'h02, 8'hFC, 8'h00, 8'h00, 8'h00};
    run_model();
    run_stream(0, m_nacc);

    do_reset();
    stream = '{8'h00, 8'h01, 8'h12, 8'h00};
    run_model();
    run_stream(0, m_nacc);

    // Abort mid-DATA, then a fresh stream must load cleanly.
    do_reset();
    stream = '{8'h10, 8'h02, 8'hAA, 8'h55, 8'hEF, 8'h00, 8'h00, 8'h00};
    run_model();
    run_stream(0, 3);
    do_reset();
    stream = '{8'h20, 8'h01, 8'h77, 8'h68, 8'h00, 8'h00, 8'h00};
    run_model();
    run_stream(0, m_nacc);

    do_reset();
    stream.delete();
    add_record(8'($urandom), 255, 1'b0);
    add_record(8'($urandom), 0, 1'b0);
    run_model();
    run_stream(2, m_nacc);

    repeat (8) begin
      stream.delete();
      for (int r = 0; r < int'($urandom_range(1, 3)); r++) begin
        add_record(8'($urandom), int'($urandom_range(1, 8)), $urandom_range(0, 5) == 0);
      end
      add_record(8'($urandom), 0, $urandom_range(0, 5) == 0);
      run_model();
      do_reset();
      run_stream(int'($urandom_range(0, 2)), m_nacc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
